logic_e_array: RTL
==================

LOGIC_E_ARRAY -- requirements
Module: logic_e_array

Interface
REQ-001 SHALL have parameter NUM_IN, default 6: number of primary inputs.
REQ-002 SHALL have parameter NUM_LE, default 8: number of logic elements (LEs).
REQ-003 SHALL derive localparams from the parameters:
- POOL = NUM_IN+NUM_LE.
- SEL_W = clog2(POOL), which is 4 at defaults.
- LE_CFG_W = 3+2*SEL_W, which is 11 at defaults.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have the following ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- all_inputs  in  NUM_IN  primary inputs.
- eval_en  in  1  LE output register update enable.
- cfg_start  in  1  one-cycle pulse that begins a configuration load.
- cfg_valid  in  1  configuration beat valid.
- cfg_data  in  LE_CFG_W  one LE configuration word.
- cfg_ready  out  1  array accepts a beat.
- cfg_done  out  1  one-cycle pulse when the new configuration is committed.
- busy  out  1  load in progress.
- le_out  out  NUM_LE  registered LE outputs.

Function
REQ-006 SHALL form the operand pool from index 0 to POOL-1: pool[i] = all_inputs[i] for i<NUM_IN, and pool[NUM_IN+j] = le_out[j].
REQ-007 SHALL lay out each config word as follows: bits [2:0] are func, bits [3+SEL_W-1:3] are sel_a, and bits [LE_CFG_W-1:3+SEL_W] are sel_b.
REQ-008 SHALL encode func as: 0 AND, 1 OR, 2 NOT a, 3 XOR, 4 XNOR, 5 NAND, 6 NOR, 7 BUF a, where a=pool[sel_a] and b=pool[sel_b]; b is ignored for func 2 and 7.
REQ-009 SHALL treat any selector >= POOL as selecting constant 0.
REQ-010 SHALL register each LE result: when eval_en=1, le_out[k] at cycle t+1 is computed from pool and active config at cycle t, giving one-cycle latency; when eval_en=0, le_out holds.
REQ-011 SHALL allow LE-to-LE references, including a self-reference, with no combinational loop, because pool reads registered le_out.
REQ-012 SHALL keep two config stores per LE: an active store, which drives evaluation, and a shadow store, which is written during load.
REQ-013 SHALL implement FSM states IDLE and LOAD:
- IDLE: cfg_ready=0 and busy=0; cfg_start moves the FSM to LOAD and clears the beat counter.
- LOAD: cfg_ready=1 and busy=1; each cycle with cfg_valid=1 writes cfg_data into shadow[count] and increments count.
- After the beat with count=NUM_LE-1 is accepted, the next cycle copies all shadow words into the active store at once, pulses cfg_done for one cycle, and returns to IDLE.
REQ-014 SHALL load beat k into LE k, with LE0 first.
REQ-015 SHALL keep evaluating with the old active config throughout LOAD; the new config first affects le_out on the cycle after cfg_done.
REQ-016 SHALL treat cfg_start asserted during LOAD as a restart: the count returns to 0, beats already received are discarded, and no commit occurs; any beat presented in that same cycle is dropped.
REQ-017 SHALL ignore cfg_valid while in IDLE.
REQ-018 SHALL leave le_out unchanged on the commit cycle apart from its normal evaluation.

Reset
REQ-019 SHALL, while rst_n=0, asynchronously clear the following: le_out=0, active and shadow stores=0, count=0, FSM=IDLE, cfg_ready=0, cfg_done=0, busy=0.
REQ-020 SHALL treat reset asserted mid-LOAD as aborting the load with no commit; the active config is the all-zero config (AND of pool[0],pool[0]).
REQ-021 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-022 SHALL honour the macro LOGIC_E_ARRAY_FEEDBACK_EN:
- When defined, pool indices >= NUM_IN read le_out as in REQ-006.
- When undefined, those indices read constant 0, LE outputs never feed LEs, and all widths are unchanged.

Verification
REQ-023 SHALL cover a basic load and evaluation at defaults:
- Stimulus: load LE0 with func=3, sel_a=0, sel_b=1; all_inputs=6'b000001; eval_en=1.
- Response: cfg_done pulses once; two cycles later le_out[0]=1; with all_inputs=6'b000011, le_out[0]=0.
REQ-024 SHALL cover feedback, with FEEDBACK_EN defined:
- Stimulus: LE0 func=2, sel_a=6 (self).
- Response: le_out[0] toggles 0,1,0,1 on successive cycles after commit; with the macro undefined, le_out[0] is stuck at 1.
REQ-025 SHALL cover double buffering:
- Stimulus: during a load of all-ones func=1 configs, le_out keeps the old config's results.
- Response: le_out changes only on the cycle after cfg_done.
REQ-026 SHALL cover restart and out-of-range selection:
- Stimulus: 3 beats, then cfg_start, then 8 beats.
- Response: exactly one cfg_done, after the 8th beat of the second sequence.
- Stimulus: sel_a=15, func=7.
- Response: le_out=0.
REQ-027 SHALL cover reset mid-load:
- Stimulus: drop rst_n after 4 beats.
- Response: all outputs are immediately 0; cfg_done never pulses; post-reset le_out[k]=all_inputs[0] for every k.

Source files
------------

// File: rtl/logic_e_array.sv
`default_nettype none
// ============================================================================
// Module      : logic_e_array
// Description : NUM_LE registered logic elements over a pool of primary inputs
//               and LE outputs, with a double-buffered configuration store.
//               Define LOGIC_E_ARRAY_FEEDBACK_EN to let LE outputs feed LEs.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_e_array #(
  parameter int NUM_IN = 6,
  parameter int NUM_LE = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_IN-1:0]                    all_inputs,
  input  logic                                 eval_en,
  input  logic                                 cfg_start,
  input  logic                                 cfg_valid,
  input  logic [3+2*$clog2(NUM_IN+NUM_LE)-1:0] cfg_data,
  output logic                                 cfg_ready,
  output logic                                 cfg_done,
  output logic                                 busy,
  output logic [NUM_LE-1:0]                    le_out
);

  localparam int POOL     = NUM_IN + NUM_LE;
  localparam int SEL_W    = $clog2(POOL);
  localparam int LE_CFG_W = 3 + 2 * SEL_W;
  localparam int EXT_W    = 1 << SEL_W;
  localparam int CNT_W    = (NUM_LE > 1) ? $clog2(NUM_LE) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_LE - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [LE_CFG_W-1:0] r_active [NUM_LE];
  logic [LE_CFG_W-1:0] r_shadow [NUM_LE];
  logic [NUM_LE-1:0]   r_le_out;
  logic                r_cfg_ready;
  logic                r_cfg_done;
  logic                r_busy;

  logic [EXT_W-1:0]    w_pool;
  logic [NUM_LE-1:0]   w_le_next;

  // Pool is zero-padded to a power of two so out-of-range selectors read 0.
  always_comb begin
    w_pool = '0;
    w_pool[NUM_IN-1:0] = all_inputs;
`ifdef LOGIC_E_ARRAY_FEEDBACK_EN
    w_pool[POOL-1:NUM_IN] = r_le_out;
`endif
  end

  for (genvar k = 0; k < NUM_LE; k++) begin : g_le
    logic [2:0]       w_func;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_a;
    logic             w_b;
    logic             w_res;

    assign w_func  = r_active[k][2:0];
    assign w_sel_a = r_active[k][3 +: SEL_W];
    assign w_sel_b = r_active[k][3+SEL_W +: SEL_W];
    assign w_a     = w_pool[w_sel_a];
    assign w_b     = w_pool[w_sel_b];

    always_comb begin
      w_res = 1'b0;
      case (w_func)
        3'd0:    w_res = w_a & w_b;
        3'd1:    w_res = w_a | w_b;
        3'd2:    w_res = ~w_a;
        3'd3:    w_res = w_a ^ w_b;
        3'd4:    w_res = ~(w_a ^ w_b);
        3'd5:    w_res = ~(w_a & w_b);
        3'd6:    w_res = ~(w_a | w_b);
        default: w_res = w_a;
      endcase
    end

    assign w_le_next[k] = w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_le_out <= '0;
    end else if (eval_en) begin
      r_le_out <= w_le_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < NUM_LE; k++) begin
        r_active[k] <= '0;
        r_shadow[k] <= '0;
      end
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_state     <= ST_LOAD;
            r_count     <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A restart wins over a beat presented in the same cycle.
          if (cfg_start) begin
            r_count <= '0;
          end else if (cfg_valid) begin
            r_shadow[r_count] <= cfg_data;
            if (r_count == LAST_BEAT) begin
              for (int k = 0; k < NUM_LE - 1; k++) begin
                r_active[k] <= r_shadow[k];
              end
              r_active[NUM_LE-1] <= cfg_data;
              r_state     <= ST_IDLE;
              r_count     <= '0;
              r_cfg_ready <= 1'b0;
              r_busy      <= 1'b0;
              r_cfg_done  <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign le_out    = r_le_out;
  assign cfg_ready = r_cfg_ready;
  assign cfg_done  = r_cfg_done;
  assign busy      = r_busy;

endmodule
`default_nettype wire
